vga_scan_controller: RTL and testbench



---
 rtl/vga_pkg.sv | 40 ++++
 rtl/vga_counter.sv | 44 ++++
 rtl/vga_scan_controller.sv | 98 +++++++++
 tb/tb_vga_scan_controller.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing constants and shared types for the VGA scan controller
package vga_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  localparam int unsigned H_TOTAL  = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int unsigned V_TOTAL  = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  localparam int unsigned HS_START = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int unsigned HS_END   = HS_START + H_SYNC_DEF - 1;
  localparam int unsigned VS_START = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int unsigned VS_END   = VS_START + V_SYNC_DEF - 1;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vga_out_t;

  localparam vga_out_t VGA_OUT_RESET = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0,
                                         r: 8'h00, g: 8'h00, b: 8'h00};

  // Inclusive window test; all operands stay unsigned.
  function automatic logic in_span(logic [CNT_W-1:0] pos, logic [CNT_W-1:0] lo,
                                   logic [CNT_W-1:0] hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/vga_counter.sv
// rtl/vga_counter.sv - pixel enable divider and horizontal/vertical scan counters
module vga_counter
  import vga_pkg::*;
#(
  parameter int unsigned LINE_LEN    = H_TOTAL,
  parameter int unsigned FRAME_LINES = V_TOTAL
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             pix_en,
  output logic [CNT_W-1:0] hc,
  output logic [CNT_W-1:0] vc,
  output logic             line_wrap,
  output logic             last_line
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(LINE_LEN - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(FRAME_LINES - 1);

  logic line_end;

  assign line_end  = (hc == H_LAST);
  assign last_line = (vc == V_LAST);
  assign line_wrap = pix_en && line_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en <= 1'b0;
      hc     <= '0;
      vc     <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (line_end) begin
          hc <= '0;
          vc <= last_line ? '0 : vc + CNT_W'(1);
        end else begin
          hc <= hc + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/vga_scan_controller.sv
// rtl/vga_scan_controller.sv - VGA raster timing with aligned registered sync, blank and colour
module vga_scan_controller
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [7:0]       Red,
  input  logic [7:0]       Green,
  input  logic [7:0]       Blue,
  output logic [CNT_W-1:0] DrawX,
  output logic [CNT_W-1:0] DrawY,
  output logic             pixel_clk,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK_N,
  output logic [7:0]       VGA_R,
  output logic [7:0]       VGA_G,
  output logic [7:0]       VGA_B,
  output logic             frame_start
);

  localparam int unsigned LINE_LEN    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_VIS_END = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_END = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_LO     = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_HI     = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_LO     = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_HI     = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic             pix_en;
  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;
  logic             line_wrap;
  logic             last_line;
  logic             visible;
  vga_out_t         out_d;
  vga_out_t         out_q;

  vga_counter #(
    .LINE_LEN    (LINE_LEN),
    .FRAME_LINES (FRAME_LINES)
  ) u_counter (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .pix_en    (pix_en),
    .hc        (hc),
    .vc        (vc),
    .line_wrap (line_wrap),
    .last_line (last_line)
  );

  assign DrawX     = hc;
  assign DrawY     = vc;
  assign pixel_clk = pix_en;

  // Decode the pixel currently on DrawX/DrawY; it lands in out_q one pixel later.
  always_comb begin
    visible       = (hc < H_VIS_END) && (vc < V_VIS_END);
    out_d         = VGA_OUT_RESET;
    out_d.hs      = ~in_span(hc, HS_LO, HS_HI);
    out_d.vs      = ~in_span(vc, VS_LO, VS_HI);
    out_d.blank_n = visible;
    out_d.r       = visible ? Red   : 8'h00;
    out_d.g       = visible ? Green : 8'h00;
    out_d.b       = visible ? Blue  : 8'h00;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_q       <= VGA_OUT_RESET;
      frame_start <= 1'b0;
    end else begin
      frame_start <= line_wrap && last_line;
      if (pix_en) begin
        out_q <= out_d;
      end
    end
  end

  assign VGA_HS      = out_q.hs;
  assign VGA_VS      = out_q.vs;
  assign VGA_BLANK_N = out_q.blank_n;
  assign VGA_R       = out_q.r;
  assign VGA_G       = out_q.g;
  assign VGA_B       = out_q.b;

endmodule

// File: tb/tb_vga_scan_controller.sv
// tb/tb_vga_scan_controller.sv - scoreboard bench for vga_scan_controller (reduced and full timing)
module tb_vga_scan_controller;
  import vga_pkg::*;

  localparam int HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] Red = 8'hFF, Green = 8'hFF, Blue = 8'hFF;

  logic [9:0] DrawX, DrawY;
  logic       pixel_clk, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  logic [9:0] f_x, f_y;
  logic       f_pclk, f_hs, f_vs, f_blank_n, f_fs;
  logic [7:0] f_r, f_g, f_b;

  always #5 Clk = ~Clk;

  vga_scan_controller #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Red(Red), .Green(Green), .Blue(Blue),
    .DrawX(DrawX), .DrawY(DrawY), .pixel_clk(pixel_clk),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .frame_start(frame_start)
  );

  vga_scan_controller dut_full (
    .Clk(Clk), .Reset_n(Reset_n), .Red(Red), .Green(Green), .Blue(Blue),
    .DrawX(f_x), .DrawY(f_y), .pixel_clk(f_pclk),
    .VGA_HS(f_hs), .VGA_VS(f_vs), .VGA_BLANK_N(f_blank_n),
    .VGA_R(f_r), .VGA_G(f_g), .VGA_B(f_b), .frame_start(f_fs)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int       m_hc, m_vc, mode;
  bit       m_pix, m_fs;
  vga_out_t held;
  vga_out_t sb[$];

  function automatic vga_out_t expect_out(int hc, int vc);
    vga_out_t o;
    bit vis;
    vis       = (hc < HV) && (vc < VV);
    o.hs      = !((hc >= HV + HF) && (hc < HV + HF + HS));
    o.vs      = !((vc >= VV + VF) && (vc < VV + VF + VS));
    o.blank_n = vis;
    o.r       = !vis ? 8'h00 : (mode == 0) ? 8'hFF : 8'(hc);
    o.g       = !vis ? 8'h00 : (mode == 0) ? 8'hFF : ~8'(hc);
    o.b       = !vis ? 8'h00 : (mode == 0) ? 8'hFF : 8'(vc);
    return o;
  endfunction

  task automatic model_reset();
    m_hc = 0; m_vc = 0; m_pix = 0; m_fs = 0;
    held = VGA_OUT_RESET;
    sb.delete();
  endtask

  task automatic compare_all();
    if (sb.size() > 0) held = sb.pop_front();
    check("hs",          32'(VGA_HS),      32'(held.hs));
    check("vs",          32'(VGA_VS),      32'(held.vs));
    check("blank_n",     32'(VGA_BLANK_N), 32'(held.blank_n));
    check("r",           32'(VGA_R),       32'(held.r));
    check("g",           32'(VGA_G),       32'(held.g));
    check("b",           32'(VGA_B),       32'(held.b));
    check("drawx",       32'(DrawX),       32'(m_hc));
    check("drawy",       32'(DrawY),       32'(m_vc));
    check("pixel_clk",   32'(pixel_clk),   32'(m_pix));
    check("frame_start", 32'(frame_start), 32'(m_fs));
  endtask

  // Compare, act as the colour mapper, predict the next edge, then wait a full Clk.
  task automatic step();
    bit nf;
    compare_all();
    if (mode == 0) begin
      Red = 8'hFF; Green = 8'hFF; Blue = 8'hFF;
    end else begin
      Red = DrawX[7:0]; Green = ~DrawX[7:0]; Blue = DrawY[7:0];
    end
    nf = 0;
    if (m_pix) begin
      sb.push_back(expect_out(m_hc, m_vc));
      nf = (m_hc == HT - 1) && (m_vc == VT - 1);
      if (m_hc == HT - 1) begin
        m_hc = 0;
        m_vc = (m_vc == VT - 1) ? 0 : m_vc + 1;
      end else begin
        m_hc++;
      end
    end
    m_pix = !m_pix;
    m_fs  = nf;
    @(negedge Clk);
  endtask

  int hs_low, hs_fall, fs_seen;
  bit reached;

  initial begin
    mode = 0;
    model_reset();
    repeat (3) begin
      @(negedge Clk);
      compare_all();
    end
    check("full_hs_rst",    32'(f_hs),      32'd1);
    check("full_vs_rst",    32'(f_vs),      32'd1);
    check("full_blank_rst", 32'(f_blank_n), 32'd0);
    check("full_x_rst",     32'(f_x),       32'd0);

    Reset_n = 1'b1;
    hs_low = 0; hs_fall = -1; fs_seen = 0;
    for (int i = 1; i <= 1800; i++) begin
      if (i == 900) mode = 1;
      step();
      if (!f_hs) begin
        hs_low++;
        if (hs_fall < 0) hs_fall = i;
      end
      if (i == 1600) begin
        check("full_line_wrap_x", 32'(f_x), 32'd0);
        check("full_line_wrap_y", 32'(f_y), 32'd1);
      end
      if (frame_start) fs_seen++;
    end
    check("full_hs_fall_edge", 32'(hs_fall), 32'd1314);
    check("full_hs_low_clk",   32'(hs_low),  32'd192);
    check("full_vs_idle",      32'(f_vs),    32'd1);
    check("frame_start_count", 32'(fs_seen), 32'd2);

    reached = 0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      if (m_hc == 20 && m_vc == 5 && m_pix) reached = 1;
      else step();
    end
    check("reach_mid_frame", 32'(reached), 32'd1);

    #2 Reset_n = 1'b0;
    #1;
    check("async_drawx",   32'(DrawX),       32'd0);
    check("async_drawy",   32'(DrawY),       32'd0);
    check("async_hs",      32'(VGA_HS),      32'd1);
    check("async_blank_n", 32'(VGA_BLANK_N), 32'd0);
    check("async_r",       32'(VGA_R),       32'd0);
    check("async_pclk",    32'(pixel_clk),   32'd0);
    check("async_fs",      32'(frame_start), 32'd0);
    model_reset();
    repeat (2) begin
      @(negedge Clk);
      compare_all();
    end
    Reset_n = 1'b1;
    for (int i = 0; i < 1000; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
